// File: rtl/lcd_pkg.sv
// Shared constants, types and address helpers for the HD44780-style LCD responder.
package lcd_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned AC_W      = 7;
    localparam int unsigned RAM_DEPTH = 80;

    localparam logic [AC_W-1:0]   LINE0_BASE = 7'h00;
    localparam logic [AC_W-1:0]   LINE1_BASE = 7'h40;
    localparam int unsigned       LINE_LEN   = 40;
    localparam logic [DATA_W-1:0] SPACE      = 8'h20;

    // Instruction classes are selected by the highest set bit of the command byte
    localparam logic [DATA_W-1:0] CMD_CLEAR = 8'h01;
    localparam logic [DATA_W-1:0] CMD_HOME  = 8'h02;
    localparam logic [DATA_W-1:0] CMD_ENTRY = 8'h04;
    localparam logic [DATA_W-1:0] CMD_DISP  = 8'h08;
    localparam logic [DATA_W-1:0] CMD_SHIFT = 8'h10;
    localparam logic [DATA_W-1:0] CMD_FUNC  = 8'h20;
    localparam logic [DATA_W-1:0] CMD_CGRAM = 8'h40;
    localparam logic [DATA_W-1:0] CMD_DDRAM = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_WAIT
    } lcd_state_e;

    typedef enum logic [3:0] {
        OP_NOP,
        OP_CLEAR,
        OP_HOME,
        OP_ENTRY,
        OP_DISP,
        OP_SHIFT,
        OP_FUNC,
        OP_CGRAM,
        OP_DDRAM
    } lcd_op_e;

    typedef struct packed {
        logic              rs;
        logic              rw;
        logic [DATA_W-1:0] data;
    } host_req_t;

    function automatic lcd_op_e decode_op(input logic [DATA_W-1:0] d);
        if ((d & CMD_DDRAM) != '0)      return OP_DDRAM;
        else if ((d & CMD_CGRAM) != '0) return OP_CGRAM;
        else if ((d & CMD_FUNC) != '0)  return OP_FUNC;
        else if ((d & CMD_SHIFT) != '0) return OP_SHIFT;
        else if ((d & CMD_DISP) != '0)  return OP_DISP;
        else if ((d & CMD_ENTRY) != '0) return OP_ENTRY;
        else if ((d & CMD_HOME) != '0)  return OP_HOME;
        else if ((d & CMD_CLEAR) != '0) return OP_CLEAR;
        return OP_NOP;
    endfunction

    function automatic logic ac_valid(input logic [AC_W-1:0] ac);
        return (ac < LINE0_BASE + AC_W'(LINE_LEN)) ||
               ((ac >= LINE1_BASE) && (ac < LINE1_BASE + AC_W'(LINE_LEN)));
    endfunction

    // Line ends wrap onto the other line so the two lines form one 80-entry ring
    function automatic logic [AC_W-1:0] ac_step(input logic [AC_W-1:0] ac, input logic inc);
        logic [AC_W-1:0] line0_last;
        logic [AC_W-1:0] line1_last;
        line0_last = LINE0_BASE + AC_W'(LINE_LEN - 1);
        line1_last = LINE1_BASE + AC_W'(LINE_LEN - 1);
        if (inc) begin
            if (ac == line0_last)      return LINE1_BASE;
            else if (ac == line1_last) return LINE0_BASE;
            else                       return ac + AC_W'(1);
        end else begin
            if (ac == LINE0_BASE)      return line1_last;
            else if (ac == LINE1_BASE) return line0_last;
            else                       return ac - AC_W'(1);
        end
    endfunction

    function automatic logic [AC_W-1:0] ac_index(input logic [AC_W-1:0] ac);
        if (ac >= LINE1_BASE) return ac - LINE1_BASE + AC_W'(LINE_LEN);
        return ac - LINE0_BASE;
    endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display RAM: one write port, a combinational read port for the address
// counter and a registered debug read port.
module lcd_ddram
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AC_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AC_W-1:0]   ac_raddr,
    output logic [DATA_W-1:0] ac_rdata,
    input  logic [AC_W-1:0]   dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    logic [DATA_W-1:0] mem_q [RAM_DEPTH];
    logic [DATA_W-1:0] dbg_rdata_d;
    logic [DATA_W-1:0] dbg_rdata_q;

    // Storage is deliberately unreset; the power-on clear initialises it
    always_ff @(posedge clk) begin
        if (we && (waddr < AC_W'(RAM_DEPTH))) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_comb begin
        ac_rdata    = '0;
        dbg_rdata_d = '0;
        if (ac_raddr < AC_W'(RAM_DEPTH)) begin
            ac_rdata = mem_q[ac_raddr];
        end
        if (dbg_raddr < AC_W'(RAM_DEPTH)) begin
            dbg_rdata_d = mem_q[dbg_raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rdata_q <= '0;
        end else begin
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: rtl/lcd_responder.sv
// Character-LCD controller model: host strobe interface, instruction decode,
// busy timing and the DDRAM clear/fill sequencer.
module lcd_responder
    import lcd_pkg::*;
#(
    parameter int unsigned BUSY_CYCLES  = 40,
    parameter int unsigned CLEAR_CYCLES = 1640
) (
    input  logic              clk,
    input  logic              rstBt,
    input  logic              en,
    input  logic              RS,
    input  logic              RW,
    input  logic [DATA_W-1:0] dataIn,
    output logic [DATA_W-1:0] dataOut,
    output logic              dataOe,
    output logic              busy,
    output logic              ovrErr,
    output logic              dispOn,
    output logic              cursOn,
    output logic              blinkOn,
    input  logic [AC_W-1:0]   rdAddr,
    output logic [DATA_W-1:0] rdData
);

    localparam int unsigned CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    lcd_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AC_W-1:0]   fill_idx_q, fill_idx_d;
    logic              en_q, en_d;
    host_req_t         host_q, host_d;
    logic [AC_W-1:0]   ac_q, ac_d;
    logic              id_q, id_d;
    logic              sh_q, sh_d;
    logic              dl_q, dl_d;
    logic              n_q, n_d;
    logic              f_q, f_d;
    logic              disp_q, disp_d;
    logic              curs_q, curs_d;
    logic              blink_q, blink_d;
    logic              ovr_q, ovr_d;
    logic              busy_q, busy_d;

    logic              commit_c;
    lcd_op_e           op_c;
    logic              ram_we_c;
    logic [AC_W-1:0]   ram_waddr_c;
    logic [DATA_W-1:0] ram_wdata_c;
    logic [DATA_W-1:0] ac_rdata;
    logic              data_oe_c;
    logic [DATA_W-1:0] data_out_c;

    // Entry shift and function-set bits are held but have no modelled effect
    logic              unused_mode;
    assign unused_mode = ^{sh_q, dl_q, n_q, f_q};

    lcd_ddram u_ddram (
        .clk       (clk),
        .rst_n     (rstBt),
        .we        (ram_we_c),
        .waddr     (ram_waddr_c),
        .wdata     (ram_wdata_c),
        .ac_raddr  (ac_index(ac_q)),
        .ac_rdata  (ac_rdata),
        .dbg_raddr (rdAddr),
        .dbg_rdata (rdData)
    );

    assign commit_c = en_q && !en;

    // Read bus follows the live strobe so the host sees data before its falling edge
    always_comb begin
        data_oe_c  = rstBt && en && RW;
        data_out_c = '0;
        if (data_oe_c) begin
            data_out_c = RS ? ac_rdata : {busy_q, ac_q};
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_idx_d  = fill_idx_q;
        en_d        = en;
        host_d      = host_q;
        ac_d        = ac_q;
        id_d        = id_q;
        sh_d        = sh_q;
        dl_d        = dl_q;
        n_d         = n_q;
        f_d         = f_q;
        disp_d      = disp_q;
        curs_d      = curs_q;
        blink_d     = blink_q;
        ovr_d       = ovr_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = fill_idx_q;
        ram_wdata_c = SPACE;
        op_c        = decode_op(host_q.data);

        if (en) begin
            host_d.rs   = RS;
            host_d.rw   = RW;
            host_d.data = dataIn;
        end

        // The busy counter keeps running through FILL so clear time is CLEAR_CYCLES total
        case (state_q)
            ST_FILL: begin
                ram_we_c = 1'b1;
                cnt_d    = cnt_q - CNT_W'(1);
                if (fill_idx_q == AC_W'(RAM_DEPTH - 1)) begin
                    fill_idx_d = '0;
                    if (cnt_q == '0) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    fill_idx_d = fill_idx_q + AC_W'(1);
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (commit_c) begin
            if (host_q.rw) begin
                if (host_q.rs) begin
                    ac_d = ac_step(ac_q, id_q);
                end
            end else if (state_q != ST_IDLE) begin
                ovr_d = 1'b1;
            end else if (host_q.rs) begin
                ram_we_c    = 1'b1;
                ram_waddr_c = ac_index(ac_q);
                ram_wdata_c = host_q.data;
                ac_d        = ac_step(ac_q, id_q);
                state_d     = ST_WAIT;
                cnt_d       = CNT_W'(BUSY_CYCLES - 1);
            end else begin
                state_d = ST_WAIT;
                cnt_d   = CNT_W'(BUSY_CYCLES - 1);
                case (op_c)
                    OP_NOP: state_d = ST_IDLE;
                    OP_CLEAR: begin
                        state_d    = ST_FILL;
                        cnt_d      = CNT_W'(CLEAR_CYCLES - 1);
                        fill_idx_d = '0;
                        ac_d       = LINE0_BASE;
                        id_d       = 1'b1;
                    end
                    OP_HOME: begin
                        cnt_d = CNT_W'(CLEAR_CYCLES - 1);
                        ac_d  = LINE0_BASE;
                    end
                    OP_ENTRY: begin
                        id_d = host_q.data[1];
                        sh_d = host_q.data[0];
                    end
                    OP_DISP: begin
                        disp_d  = host_q.data[2];
                        curs_d  = host_q.data[1];
                        blink_d = host_q.data[0];
                    end
                    OP_SHIFT: begin
                        if (!host_q.data[3]) begin
                            ac_d = ac_step(ac_q, host_q.data[2]);
                        end
                    end
                    OP_FUNC: begin
                        dl_d = host_q.data[4];
                        n_d  = host_q.data[3];
                        f_d  = host_q.data[2];
                    end
                    OP_DDRAM: begin
                        ac_d = ac_valid(host_q.data[6:0]) ? host_q.data[6:0] : LINE0_BASE;
                    end
                    default: ;
                endcase
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // Reset lands in FILL so every release performs the power-on clear
    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            state_q    <= ST_FILL;
            cnt_q      <= CNT_W'(CLEAR_CYCLES - 1);
            fill_idx_q <= '0;
            en_q       <= 1'b0;
            host_q     <= '0;
            ac_q       <= LINE0_BASE;
            id_q       <= 1'b1;
            sh_q       <= 1'b0;
            dl_q       <= 1'b1;
            n_q        <= 1'b1;
            f_q        <= 1'b0;
            disp_q     <= 1'b0;
            curs_q     <= 1'b0;
            blink_q    <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fill_idx_q <= fill_idx_d;
            en_q       <= en_d;
            host_q     <= host_d;
            ac_q       <= ac_d;
            id_q       <= id_d;
            sh_q       <= sh_d;
            dl_q       <= dl_d;
            n_q        <= n_d;
            f_q        <= f_d;
            disp_q     <= disp_d;
            curs_q     <= curs_d;
            blink_q    <= blink_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

    assign dataOe  = data_oe_c;
    assign dataOut = data_out_c;
    assign busy    = busy_q;
    assign ovrErr  = ovr_q;
    assign dispOn  = disp_q;
    assign cursOn  = curs_q;
    assign blinkOn = blink_q;

endmodule

// File: tb/tb_lcd_responder.sv
// Directed plus randomized bench for lcd_responder against a linear-position
// behavioural model of the display, address counter and busy timing.
module tb_lcd_responder;

    localparam int unsigned BUSY  = 40;
    localparam int unsigned CLEAR = 1640;

    logic       clk    = 1'b0;
    logic       rstBt  = 1'b0;
    logic       en     = 1'b0;
    logic       RS     = 1'b0;
    logic       RW     = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic [6:0] rdAddr = 7'd0;
    logic [7:0] dataOut;
    logic [7:0] rdData;
    logic       dataOe, busy, ovrErr, dispOn, cursOn, blinkOn;

    lcd_responder #(.BUSY_CYCLES(BUSY), .CLEAR_CYCLES(CLEAR)) dut (
        .clk     (clk),
        .rstBt   (rstBt),
        .en      (en),
        .RS      (RS),
        .RW      (RW),
        .dataIn  (dataIn),
        .dataOut (dataOut),
        .dataOe  (dataOe),
        .busy    (busy),
        .ovrErr  (ovrErr),
        .dispOn  (dispOn),
        .cursOn  (cursOn),
        .blinkOn (blinkOn),
        .rdAddr  (rdAddr),
        .rdData  (rdData)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: display memory by linear position, cursor as position 0..79
    logic [7:0] mem_m [80];
    int         pos;
    bit         id_m;
    bit         ovr_m;
    logic [2:0] disp_m;
    int         busy_left;
    bit         in_reset = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ac_of(input int p);
        return (p < 40) ? 8'(p) : 8'(p - 40 + 'h40);
    endfunction

    function automatic int step_pos(input int p, input bit inc);
        return inc ? (p + 1) % 80 : (p + 79) % 80;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 80; i++) mem_m[i] = 8'h20;
        pos       = 0;
        id_m      = 1'b1;
        ovr_m     = 1'b0;
        disp_m    = 3'b000;
        busy_left = CLEAR;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (busy_left > 0) busy_left--;
        if (!in_reset) begin
            chk("flags{busy,ovr,disp,curs,blink}", {busy, ovrErr, dispOn, cursOn, blinkOn},
                {(busy_left > 0), ovr_m, disp_m});
        end
    endtask

    task automatic wait_idle();
        while (busy_left > 0) tick();
        tick();
    endtask

    task automatic model_cmd(input logic [7:0] d, output int dur);
        int a;
        dur = BUSY;
        a   = int'(d) - 128;
        if (d == 8'h00) dur = 0;
        else if (d == 8'h01) begin
            for (int i = 0; i < 80; i++) mem_m[i] = 8'h20;
            pos  = 0;
            id_m = 1'b1;
            dur  = CLEAR;
        end else if (d < 8'h04) begin
            pos = 0;
            dur = CLEAR;
        end else if (d < 8'h08) id_m = d[1];
        else if (d < 8'h10) disp_m = d[2:0];
        else if (d < 8'h20) begin
            if (!d[3]) pos = step_pos(pos, d[2]);
        end else if (d < 8'h80) begin
        end else begin
            if (a < 40) pos = a;
            else if (a >= 64 && a < 104) pos = a - 64 + 40;
            else pos = 0;
        end
    endtask

    task automatic host_write(input bit rs, input logic [7:0] d);
        int dur;
        en = 1'b1; RS = rs; RW = 1'b0; dataIn = d;
        tick();
        en = 1'b0; dataIn = 8'($urandom);
        dur = 0;
        if (busy_left > 0) ovr_m = 1'b1;
        else if (rs) begin
            mem_m[pos] = d;
            pos = step_pos(pos, id_m);
            dur = BUSY;
        end else model_cmd(d, dur);
        if (dur > 0) busy_left = dur + 1;
        tick();
    endtask

    task automatic host_read(input bit rs);
        logic [7:0] a;
        logic [7:0] exp;
        en = 1'b1; RS = rs; RW = 1'b1;
        #1;
        a   = ac_of(pos);
        exp = rs ? mem_m[pos] : {(busy_left > 0), a[6:0]};
        chk("read_oe", {31'd0, dataOe}, 32'd1);
        if (rs) chk("data_read", dataOut, exp);
        else    chk("status_read", dataOut, exp);
        tick();
        en = 1'b0; RW = 1'b0;
        if (rs) pos = step_pos(pos, id_m);
        tick();
        chk("bus_released", {dataOe, dataOut}, 9'd0);
    endtask

    task automatic check_ram();
        for (int i = 0; i < 80; i++) begin
            rdAddr = 7'(i);
            tick();
            chk($sformatf("ddram[%0d]", i), rdData, mem_m[i]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        model_reset();
        en = 1'b1; RW = 1'b1;
        repeat (3) tick();
        chk("reset_busy", {31'd0, busy}, 32'd1);
        chk("reset_flags", {ovrErr, dispOn, cursOn, blinkOn}, 4'd0);
        chk("reset_rddata", rdData, 8'h00);
        chk("reset_bus", {dataOe, dataOut}, 9'd0);
        en = 1'b0; RW = 1'b0;

        // Power-on clear
        rstBt = 1'b1; in_reset = 1'b0; model_reset();
        wait_idle();
        check_ram();
        host_read(1'b0);

        // Entry mode then two characters
        host_write(1'b0, 8'h06); wait_idle();
        host_write(1'b1, 8'h41); wait_idle();
        host_write(1'b1, 8'h42); wait_idle();
        rdAddr = 7'd0; tick(); chk("dir_rd0", rdData, 8'h41);
        rdAddr = 7'd1; tick(); chk("dir_rd1", rdData, 8'h42);
        host_read(1'b0);

        // Line wrap forward and backward
        host_write(1'b0, 8'hA7); wait_idle();
        host_write(1'b1, 8'h58); wait_idle();
        rdAddr = 7'd39; tick(); chk("dir_rd39", rdData, 8'h58);
        host_read(1'b0);
        host_write(1'b0, 8'h80); wait_idle();
        host_write(1'b0, 8'h04); wait_idle();
        host_write(1'b1, 8'h5A); wait_idle();
        host_read(1'b0);
        host_write(1'b0, 8'hB0); wait_idle();
        host_read(1'b0);

        // Write while busy is dropped; reads during busy
        host_write(1'b1, 8'h30);
        repeat (3) tick();
        host_write(1'b1, 8'h31);
        host_read(1'b0);
        host_read(1'b1);
        wait_idle();
        check_ram();

        // Display control and clear
        host_write(1'b0, 8'h0F); wait_idle();
        host_write(1'b0, 8'h01); wait_idle();
        check_ram();
        host_read(1'b0);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 10);
            case (r)
                0, 1, 2, 3: host_write(1'b1, 8'($urandom));
                4: host_write(1'b0, 8'h04 | 8'($urandom_range(0, 3)));
                5: host_write(1'b0, 8'h08 | 8'($urandom_range(0, 7)));
                6: host_write(1'b0, 8'h10 | 8'($urandom_range(0, 15)));
                7: host_write(1'b0, 8'h80 | 8'($urandom_range(0, 127)));
                8: host_read(1'b1);
                9: host_read(1'b0);
                default: begin
                    case ($urandom_range(0, 3))
                        0: host_write(1'b0, 8'h00);
                        1: host_write(1'b0, 8'h20 | 8'($urandom_range(0, 31)));
                        2: host_write(1'b0, 8'h40 | 8'($urandom_range(0, 63)));
                        default: host_write(1'b0, 8'h02 | 8'($urandom_range(0, 1)));
                    endcase
                end
            endcase
            repeat ($urandom_range(0, 50)) tick();
        end
        wait_idle();
        check_ram();
        host_read(1'b0);

        // Reset during the clear fill
        host_write(1'b0, 8'h01);
        repeat (20) tick();
        en = 1'b1; RW = 1'b1;
        rstBt = 1'b0; in_reset = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd1);
        chk("midreset_flags", {ovrErr, dispOn, cursOn, blinkOn}, 4'd0);
        chk("midreset_rddata", rdData, 8'h00);
        chk("midreset_bus", {dataOe, dataOut}, 9'd0);
        repeat (2) tick();
        en = 1'b0; RW = 1'b0;
        rstBt = 1'b1; in_reset = 1'b0; model_reset();
        wait_idle();
        check_ram();
        host_read(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
